// File: rtl/tipi_serial_tx_if.sv
// Request and serial-link signals of the TIPI FPGA-to-RPi transmitter.
//
// Request protocol: data_req / control_req are single-cycle strobes. The
// byte on data_in / control_in is captured on the same rising clk edge the
// strobe is seen high. There is no back-pressure: a strobe is always accepted,
// and a newer strobe on a channel replaces any byte that has not started
// shifting yet. busy is high from LOAD through DONE. done pulses for one cycle
// at the end of a frame, and done_ch names the channel of that frame.
interface tipi_serial_tx_if;
  logic [7:0] data_in;
  logic       data_req;
  logic [7:0] control_in;
  logic       control_req;
  logic       busy;
  logic       done;
  logic       done_ch;
  logic       tx_dclk;
  logic       tx_cclk;
  logic       tx_sdata;
  logic       tx_le;
  logic [2:0] dbg_state;

  // Requester side: TI latch registers, or the testbench.
  modport master (
    output data_in, data_req, control_in, control_req,
    input  busy, done, done_ch, tx_dclk, tx_cclk, tx_sdata, tx_le, dbg_state
  );

  // Transmitter side.
  modport slave (
    input  data_in, data_req, control_in, control_req,
    output busy, done, done_ch, tx_dclk, tx_cclk, tx_sdata, tx_le, dbg_state
  );
endinterface

// File: rtl/tipi_serial_tx.sv
// TIPI serial transmitter: sends TI-written data/control bytes to the RPi over
// the shift/latch link (per-channel shift clock, shared data, shared latch).
// A frame has 9 rising edges on the selected channel clock. Edges 1-8 shift
// the byte MSB first with tx_le low. Edge 9 has tx_le high and latches the
// byte in the receiver.
module tipi_serial_tx #(
  parameter int unsigned CLK_DIV = 4  // clk cycles per shift-clock half period, 1..255
) (
  input  logic             clk,
  input  logic             rst,
  tipi_serial_tx_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_LOW  = 3'd2,
    ST_HIGH = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  // Holding registers and pending flags, one set per channel.
  logic [7:0] dhold_q, dhold_d;
  logic [7:0] chold_q, chold_d;
  logic       dpend_q, dpend_d;
  logic       cpend_q, cpend_d;

  // Frame engine.
  state_t     state_q, state_d;
  logic       sel_q, sel_d;        // channel of the frame in flight: 1 = control
  logic [7:0] shift_q, shift_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] div_q, div_d;

  // Registered outputs.
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       done_ch_q, done_ch_d;
  logic       dclk_q, dclk_d;
  logic       cclk_q, cclk_d;
  logic       sdata_q, sdata_d;
  logic       le_q, le_d;

  logic [7:0] load_byte;

  assign load_byte = sel_q ? chold_q : dhold_q;

  // Capture strobes into the holding registers. The LOAD cycle clears the
  // pending flag of the channel it consumes, but a strobe in that same cycle
  // sets it again, so the new byte gets its own frame.
  always_comb begin
    dhold_d = dhold_q;
    chold_d = chold_q;
    dpend_d = dpend_q;
    cpend_d = cpend_q;
    if (state_q == ST_LOAD) begin
      if (sel_q) begin
        cpend_d = 1'b0;
      end else begin
        dpend_d = 1'b0;
      end
    end
    if (bus.data_req) begin
      dhold_d = bus.data_in;
      dpend_d = 1'b1;
    end
    if (bus.control_req) begin
      chold_d = bus.control_in;
      cpend_d = 1'b1;
    end
  end

  // Frame sequencing. The outputs are computed here for the state being
  // entered, so every pin is driven straight from a flop.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    div_d     = div_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_ch_d = 1'b0;
    dclk_d    = dclk_q;
    cclk_d    = cclk_q;
    sdata_d   = sdata_q;
    le_d      = le_q;

    case (state_q)
      ST_IDLE: begin
        if (cpend_q || dpend_q) begin
          // Control wins a tie. The channel stays fixed until DONE.
          sel_d   = cpend_q;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        shift_d  = load_byte;
        bitcnt_d = 4'd0;
        sdata_d  = load_byte[7];
        le_d     = 1'b0;
        div_d    = 8'd0;
        state_d  = ST_LOW;
      end

      ST_LOW: begin
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          if (sel_q) begin
            cclk_d = 1'b1;
          end else begin
            dclk_d = 1'b1;
          end
          state_d = ST_HIGH;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      ST_HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d  = 8'd0;
          dclk_d = 1'b0;
          cclk_d = 1'b0;
          if (bitcnt_q < 4'd7) begin
            // Next bit goes out together with the falling edge, so it is
            // stable for a full low phase before the next rising edge.
            shift_d  = {shift_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q + 4'd1;
            sdata_d  = shift_q[6];
            state_d  = ST_LOW;
          end else if (bitcnt_q == 4'd7) begin
            // All 8 bits shifted. One more clock with tx_le high latches them.
            le_d     = 1'b1;
            bitcnt_d = 4'd8;
            state_d  = ST_LOW;
          end else begin
            le_d      = 1'b0;
            sdata_d   = 1'b0;
            done_d    = 1'b1;
            done_ch_d = sel_q;
            state_d   = ST_DONE;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        dclk_d  = 1'b0;
        cclk_d  = 1'b0;
        le_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Holding-register flops. A reset drops queued bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dhold_q <= 8'd0;
      chold_q <= 8'd0;
      dpend_q <= 1'b0;
      cpend_q <= 1'b0;
    end else begin
      dhold_q <= dhold_d;
      chold_q <= chold_d;
      dpend_q <= dpend_d;
      cpend_q <= cpend_d;
    end
  end

  // Frame engine and output flops. A reset mid-frame drops the clocks
  // without a latch edge, so the receiver keeps its previous byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= 1'b0;
      shift_q   <= 8'd0;
      bitcnt_q  <= 4'd0;
      div_q     <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_ch_q <= 1'b0;
      dclk_q    <= 1'b0;
      cclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      le_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      div_q     <= div_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_ch_q <= done_ch_d;
      dclk_q    <= dclk_d;
      cclk_q    <= cclk_d;
      sdata_q   <= sdata_d;
      le_q      <= le_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.done_ch   = done_ch_q;
  assign bus.tx_dclk   = dclk_q;
  assign bus.tx_cclk   = cclk_q;
  assign bus.tx_sdata  = sdata_q;
  assign bus.tx_le     = le_q;
  assign bus.dbg_state = state_q;

endmodule

// File: doc/tipi_serial_tx.md
# tipi_serial_tx

FPGA-side serial transmitter that carries TI-written bytes (data channel and control channel) to the RPi over the TIPI shift/latch link. It uses the same wire protocol the RPi already uses to send bytes into the FPGA: per-channel shift clock, shared serial data, and shared latch-enable. It sits between the TI bus latch registers and the RPi GPIO header, so the parallel `rpi_d`/`rpi_s` pins can be replaced by four pins.

## Interface

- `CLK_DIV`, 4, `clk` cycles per shift-clock half-period; legal range 1..255.
- `clk`  in  1  50 MHz system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `data_in`  in  8  byte to send on the data channel; sampled on `data_req`.
- `data_req`  in  1  single-cycle strobe; capture `data_in` and mark the data channel pending.
- `control_in`  in  8  byte to send on the control channel; sampled on `control_req`.
- `control_req`  in  1  single-cycle strobe; capture `control_in` and mark the control channel pending.
- `busy`  out  1  high from LOAD through DONE inclusive.
- `done`  out  1  one-cycle pulse in DONE.
- `done_ch`  out  1  channel of the frame just completed: 1 = control, 0 = data; valid while `done` is high.
- `tx_dclk`  out  1  data-channel shift clock to the RPi.
- `tx_cclk`  out  1  control-channel shift clock to the RPi.
- `tx_sdata`  out  1  serial data, MSB first; shared by both channels.
- `tx_le`  out  1  latch enable; shared by both channels.

## Operation

- **Holding registers.** Each channel has an 8-bit holding register and a pending flag.
  - A strobe loads the holding register and sets the pending flag.
  - A repeated strobe before the frame starts overwrites the value; the latest value wins and only one frame is sent.
- **Arbitration.** In IDLE, if any channel is pending, go to LOAD.
  - Control has priority when both channels are pending.
  - The channel is fixed for the whole frame.
- **States and transitions.**
  - IDLE → LOAD when any channel is pending.
  - LOAD, 1 cycle:
    - copy the selected holding register to the shift register and clear that channel's pending flag;
    - set `bitcnt=0`, `tx_sdata=shift[7]`, `tx_le=0`.
  - LOW, `CLK_DIV` cycles: both clocks low.
  - HIGH, `CLK_DIV` cycles: the selected channel's clock is high; the other channel's clock stays low.
  - End of HIGH with `bitcnt<7`: shift left, `bitcnt++`, drive the next MSB on `tx_sdata`, go to LOW.
  - End of HIGH with `bitcnt==7`: set `tx_le=1`, `bitcnt=8`, go to LOW (latch pulse).
  - End of HIGH with `bitcnt==8`: set `tx_le=0`, go to DONE.
  - DONE, 1 cycle: pulse `done` and drive `done_ch`, then go to IDLE.
- **Frame contents.** Each frame is 9 rising edges on the selected clock.
  - Edges 1–8 occur with `tx_le=0` and shift the byte MSB first.
  - Edge 9 occurs with `tx_le=1`; the receiver latches the byte on this edge.
- **Strobe during a frame.**
  - A strobe on any channel while `busy` is high is captured and queued.
  - A strobe on the same channel in the same cycle as its LOAD leaves pending=1 with the new value, so a second frame follows.
- **Counters.** The half-period counter is 8 bits wide, counts 0..`CLK_DIV`-1, and wraps. `bitcnt` is 4 bits wide.
- **Reset.**
  - All outputs go to 0: clocks, `tx_sdata`, `tx_le`, `busy`, `done`, `done_ch`.
  - Pending flags clear and the FSM returns to IDLE.
  - A reset mid-frame aborts without a latch edge, so the receiver's latched byte is unchanged. Its partial shift contents are harmless, because the next frame shifts 8 full bits before latching.

## Timing

- **Frame length.** LOAD to DONE is 1 + 18·`CLK_DIV` + 1 cycles; 74 cycles at `CLK_DIV=4`.
- **Start latency.** From a strobe in IDLE, LOAD occurs on the next cycle: the strobe registers pending at edge N, LOAD runs in cycle N+1, and `busy` goes high at N+1.
- **Back-to-back frames.** Consecutive frames have at least 1 idle cycle between DONE and the next LOAD.
- **Data and latch-enable changes.** `tx_sdata` and `tx_le` change only on the cycle a LOW phase is entered (or in LOAD/DONE). They are therefore stable for at least `CLK_DIV` cycles before, and during, every rising shift-clock edge.
- **Glitch-free outputs.** All outputs come directly from flops.
- **Shift-clock rate.** Shift clock = `clk`/(2·`CLK_DIV`), which is 6.25 MHz at default.

## Test plan

- **Single data frame.**
  - Stimulus: `data_req` with `data_in=0xA5`, `CLK_DIV=4`.
  - Required: 9 `tx_dclk` rising edges with sampled `tx_sdata` = 1,0,1,0,0,1,0,1,x and `tx_le` = 0×8,1; `tx_cclk` stays low; `done`=1 with `done_ch`=0 exactly 74 cycles after LOAD.
  - Receiver-model latch = 0xA5.
- **Simultaneous requests.**
  - Stimulus: `data_req` (0x11) and `control_req` (0x22) in the same cycle.
  - Required: control frame 0x22 on `tx_cclk` first, then data frame 0x11 on `tx_dclk`, with ≥1 idle cycle between them.
- **Overwrite and queue.**
  - Stimulus: `control_req` 0x01, then `control_req` 0x02 and 0x03 during that frame.
  - Required: exactly two frames, 0x01 then 0x03.
- **Reset mid-frame.**
  - Stimulus: assert `rst` during bit 4 of 0xFF.
  - Required: all outputs 0 immediately; no latch edge; receiver latch keeps its prior value; next request 0x3C latches 0x3C.
- **Minimum divider.**
  - Stimulus: `CLK_DIV=1`, data byte 0x80.
  - Required: 20-cycle frame (LOAD to DONE); `tx_sdata` stable across each rising edge; receiver latch = 0x80.
- **Idle quiet.**
  - Stimulus: no requests for 1000 cycles after reset.
  - Required: all outputs remain 0.
